// File: rtl/register_file_module.sv
// Register file with write-back bypass and per-register pending-write
// scoreboard. It raises stall on operand hazards and on counter saturation,
// and sets a sticky error flag for write-backs that had no pending issue.
module register_file_module #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ans_wb,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              stall,
  output logic              wb_err
);

  localparam int NREG = 1 << ADDR_W;

  // r0 is never written, so it stays at its reset value of zero.
  logic [DATA_W-1:0] r_regs [NREG];
  logic [1:0]        r_pend [NREG];
  logic              r_wb_err;

  logic w_wb_live;
  logic w_dec;
  logic w_rs_hz;
  logic w_rt_hz;
  logic w_sat;
  logic w_issue_acc;

  assign w_wb_live = wb_en && (wb_addr != '0);
  // A write-back only retires a pending count when one exists.
  assign w_dec     = w_wb_live && (r_pend[wb_addr] != 2'd0);

  // Effective count is pending minus a retiring write-back this cycle.
  // Because w_dec requires a nonzero count, the effective count is nonzero
  // when pending > 1, or when pending == 1 and nothing retires it.
  assign w_rs_hz = (rs_addr != '0) &&
                   ((r_pend[rs_addr] > 2'd1) ||
                    ((r_pend[rs_addr] == 2'd1) && !(w_dec && (wb_addr == rs_addr))));
  assign w_rt_hz = (rt_addr != '0) &&
                   ((r_pend[rt_addr] > 2'd1) ||
                    ((r_pend[rt_addr] == 2'd1) && !(w_dec && (wb_addr == rt_addr))));

  // A fourth outstanding issue would wrap the 2-bit counter.
  assign w_sat = issue_en && (issue_dest != '0) &&
                 (r_pend[issue_dest] == 2'd3) &&
                 !(w_dec && (wb_addr == issue_dest));

  assign stall       = w_rs_hz || w_rt_hz || w_sat;
  assign w_issue_acc = issue_en && !stall && (issue_dest != '0);

  assign rs_data = (rs_addr == '0) ? '0 :
                   ((w_wb_live && (wb_addr == rs_addr)) ? ans_wb : r_regs[rs_addr]);
  assign rt_data = (rt_addr == '0) ? '0 :
                   ((w_wb_live && (wb_addr == rt_addr)) ? ans_wb : r_regs[rt_addr]);

  assign wb_err = r_wb_err;

  // Register array: capture write-back data for any nonzero destination.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wb_live) begin
      r_regs[wb_addr] <= ans_wb;
    end
  end

  // Pending counters: +1 on accepted issue, -1 on retiring write-back,
  // unchanged when both target the same register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_pend[i] <= 2'd0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if ((w_issue_acc && (issue_dest == ADDR_W'(i))) &&
            !(w_dec && (wb_addr == ADDR_W'(i)))) begin
          r_pend[i] <= r_pend[i] + 2'd1;
        end else if (!(w_issue_acc && (issue_dest == ADDR_W'(i))) &&
                     (w_dec && (wb_addr == ADDR_W'(i)))) begin
          r_pend[i] <= r_pend[i] - 2'd1;
        end
      end
    end
  end

  // Sticky error: a write-back to a nonzero register with nothing pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb_err <= 1'b0;
    end else if (w_wb_live && (r_pend[wb_addr] == 2'd0)) begin
      r_wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_register_file_module.sv
// Testbench for register_file_module: directed scenarios plus randomized
// traffic, checked against an array-based reference model.
module tb_register_file_module;

  logic       clk;
  logic       reset;
  logic [7:0] ans_wb;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [2:0] rs_addr;
  logic [2:0] rt_addr;
  logic [7:0] rs_data;
  logic [7:0] rt_data;
  logic       issue_en;
  logic [2:0] issue_dest;
  logic       stall;
  logic       wb_err;

  int n_cmp;
  int n_bad;

  // Reference model state
  int m_regs [8];
  int m_pend [8];
  int m_err;

  register_file_module #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .ans_wb    (ans_wb),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .issue_en  (issue_en),
    .issue_dest(issue_dest),
    .stall     (stall),
    .wb_err    (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 0;
      m_pend[i] = 0;
    end
    m_err = 0;
  endtask

  // Count still outstanding after this cycle's write-back, as seen by decode.
  function automatic int eff_pend(input int a, input logic we, input int wa);
    int e;
    if (a == 0) return 0;
    e = m_pend[a];
    if (we && wa == a && m_pend[a] > 0) e = e - 1;
    return e;
  endfunction

  // One clock cycle: drive inputs, check combinational outputs, advance model.
  task automatic cycle(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic ie, input logic [2:0] id,
                       input logic [2:0] ra, input logic [2:0] rb, input string tag);
    int  exp_rs;
    int  exp_rt;
    int  exp_stall;
    @(negedge clk);
    wb_en = we; wb_addr = wa; ans_wb = wd;
    issue_en = ie; issue_dest = id; rs_addr = ra; rt_addr = rb;
    #1;
    exp_rs = (ra == 0) ? 0 : ((we && wa == ra) ? int'(wd) : m_regs[ra]);
    exp_rt = (rb == 0) ? 0 : ((we && wa == rb) ? int'(wd) : m_regs[rb]);
    exp_stall = (eff_pend(ra, we, wa) > 0 || eff_pend(rb, we, wa) > 0 ||
                 (ie && id != 0 && eff_pend(id, we, wa) == 3)) ? 1 : 0;
    expect_eq({tag, "_rs"},    32'(rs_data), 32'(exp_rs));
    expect_eq({tag, "_rt"},    32'(rt_data), 32'(exp_rt));
    expect_eq({tag, "_stall"}, 32'(stall),   32'(exp_stall));
    expect_eq({tag, "_err"},   32'(wb_err),  32'(m_err));
    if (we && wa != 0) begin
      m_regs[wa] = int'(wd);
      if (m_pend[wa] == 0) m_err = 1;
      else m_pend[wa] = m_pend[wa] - 1;
    end
    if (ie && exp_stall == 0 && id != 0) m_pend[id] = m_pend[id] + 1;
  endtask

  task automatic idle(input logic [2:0] ra, input logic [2:0] rb, input string tag);
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, ra, rb, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_clear();
    #2;
    reset = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    model_clear();
    wb_en = 0; wb_addr = 0; ans_wb = 0; issue_en = 0; issue_dest = 0;
    rs_addr = 3'd3; rt_addr = 3'd5;
    reset = 1'b0;
    #12;
    expect_eq("rst_rs",    32'(rs_data), 32'h0);
    expect_eq("rst_rt",    32'(rt_data), 32'h0);
    expect_eq("rst_stall", 32'(stall),   32'h0);
    expect_eq("rst_err",   32'(wb_err),  32'h0);
    reset = 1'b1;

    // Write-back with no pending issue: bypass, then array, and sticky error
    cycle(1'b1, 3'd3, 8'hff, 1'b0, 3'd0, 3'd3, 3'd0, "wb3");
    idle(3'd3, 3'd0, "rd3");
    expect_eq("rd3_const", 32'(rs_data), 32'hff);
    expect_eq("err_const", 32'(wb_err), 32'h1);

    // Hazard stall released by same-cycle write-back with bypass
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 3'd0, 3'd0, "iss5");
    idle(3'd5, 3'd0, "haz5");
    expect_eq("haz5_const", 32'(stall), 32'h1);
    cycle(1'b1, 3'd5, 8'h0f, 1'b0, 3'd0, 3'd5, 3'd0, "wb5");
    expect_eq("wb5_const", 32'(rs_data), 32'h0f);

    // r0 ignores writes and issues
    cycle(1'b1, 3'd0, 8'haa, 1'b1, 3'd0, 3'd0, 3'd0, "r0");
    idle(3'd0, 3'd0, "r0_rd");

    // Saturation guard on r2
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd0, 3'd0, "sat_iss");
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd0, 3'd0, "sat_block");
    expect_eq("sat_const", 32'(stall), 32'h1);
    cycle(1'b1, 3'd2, 8'h22, 1'b1, 3'd2, 3'd0, 3'd0, "sat_wb");
    expect_eq("sat_wb_const", 32'(stall), 32'h0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 3'd2, 8'(k), 1'b0, 3'd0, 3'd2, 3'd0, "sat_drain");
    idle(3'd2, 3'd2, "sat_empty");

    // Simultaneous issue and write-back on r4
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 3'd0, 3'd0, "r4_iss");
    cycle(1'b1, 3'd4, 8'h44, 1'b1, 3'd4, 3'd0, 3'd0, "r4_both");
    idle(3'd0, 3'd4, "r4_hold");
    expect_eq("r4_const", 32'(stall), 32'h1);

    // Asynchronous reset mid-stall
    do_reset();
    cycle(1'b1, 3'd6, 8'h66, 1'b1, 3'd6, 3'd0, 3'd0, "r6_a");
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 3'd0, 3'd0, "r6_b");
    idle(3'd6, 3'd0, "r6_stall");
    @(negedge clk);
    wb_en = 0; issue_en = 0; rs_addr = 3'd6; rt_addr = 3'd0;
    #1;
    expect_eq("ar_pre_stall", 32'(stall), 32'h1);
    reset = 1'b0;
    #1;
    expect_eq("ar_stall", 32'(stall),   32'h0);
    expect_eq("ar_rs",    32'(rs_data), 32'h0);
    expect_eq("ar_err",   32'(wb_err),  32'h0);
    model_clear();
    #1;
    reset = 1'b1;
    cycle(1'b1, 3'd6, 8'h77, 1'b0, 3'd0, 3'd6, 3'd0, "ar_wb");
    idle(3'd6, 3'd0, "ar_after");
    expect_eq("ar_err_const", 32'(wb_err), 32'h1);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 2) == 0), 3'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), 3'($urandom),
            3'($urandom), 3'($urandom), "rnd");
      if (n == 200) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
